cv32e40p_obi_mem_responder: RTL and testbench

- OBI-style data-memory responder: the memory end of the core's data interface (data_req/gnt/rvalid).
- Word-organised scratchpad with byte-enable writes, a fixed response latency and a bounded number of outstanding transactions.
- Used as the data-side slave behind the core/FPU top in integration and bring-up configurations.

---
 rtl/cv32e40p_obi_mem_responder.sv | 113 +++++++++++
 tb/tb_cv32e40p_obi_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI-style data-memory responder: word-organised scratchpad with byte-enable
// writes, fixed response latency and a bounded number of outstanding transactions.
module cv32e40p_obi_mem_responder #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned RESP_LAT        = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        stall_i
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUTSTANDING);
    localparam logic [30:0] DepthW = 31'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]     word_idx;
    logic [IdxW-1:0] mem_idx;
    logic            in_range;
    logic            accept;

    logic [RESP_LAT-1:0] pipe_valid_q;
    logic [RESP_LAT-1:0] pipe_err_q;
    logic [31:0]         pipe_rdata_q [RESP_LAT];

    logic [CntW-1:0] outstanding_q, outstanding_d;

    assign word_idx = addr_i[31:2];
    assign mem_idx  = word_idx[IdxW-1:0];
    assign in_range = ({1'b0, word_idx} < DepthW);

    // A response retiring this cycle frees its slot for a same-cycle grant.
    assign gnt_o  = req_i && !stall_i && ((outstanding_q < MaxOut) || rvalid_o);
    assign accept = req_i && gnt_o;

    // Outputs come from the last pipeline stage; data and error are forced to 0 when idle.
    assign rvalid_o = pipe_valid_q[RESP_LAT-1];
    assign rdata_o  = rvalid_o ? pipe_rdata_q[RESP_LAT-1] : 32'h0;
    assign err_o    = rvalid_o && pipe_err_q[RESP_LAT-1];

    // Byte-enabled write into the array; out-of-range writes are dropped. Array is not reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response shift pipeline; read data is sampled at the accepting edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_q <= '0;
            pipe_err_q   <= '0;
            for (int unsigned i = 0; i < RESP_LAT; i++) begin
                pipe_rdata_q[i] <= 32'h0;
            end
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_err_q[0]   <= accept && !in_range;
            pipe_rdata_q[0] <= (accept && !we_i && in_range) ? mem[mem_idx] : 32'h0;
            for (int unsigned i = 1; i < RESP_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_err_q[i]   <= pipe_err_q[i-1];
                pipe_rdata_q[i] <= pipe_rdata_q[i-1];
            end
        end
    end

    // Outstanding count: +1 on accept, -1 on response, unchanged when both coincide.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, rvalid_o})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Outstanding counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

`ifndef SYNTHESIS
    a_params_legal: assert property (@(posedge clk_i)
        (DEPTH_WORDS >= 1) && (RESP_LAT >= 1) && (RESP_LAT <= 8) &&
        (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING <= 8));
    a_outstanding_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_q <= MaxOut);
    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid_o |-> (outstanding_q != '0));
`endif

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Self-checking bench: four responder instances with different latency/outstanding
// settings share one input bus; req is steered to one instance at a time.
module tb_cv32e40p_obi_mem_responder;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall;

    logic [3:0]  req_v;
    logic [3:0]  gnt_v;
    logic [3:0]  rvalid_v;
    logic [3:0]  err_v;
    logic [31:0] rdata_v [4];

    int checks = 0;
    int errors = 0;
    int lats [4] = '{1, 2, 3, 4};

    vec_t vecs [12];

    assign req_v[0] = req && (sel == 2'd0);
    assign req_v[1] = req && (sel == 2'd1);
    assign req_v[2] = req && (sel == 2'd2);
    assign req_v[3] = req && (sel == 2'd3);

    cv32e40p_obi_mem_responder #(.DEPTH_WORDS(1024), .RESP_LAT(1), .MAX_OUTSTANDING(2)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[0]), .gnt_o(gnt_v[0]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_v[0]), .rdata_o(rdata_v[0]),
        .err_o(err_v[0]), .stall_i(stall));

    cv32e40p_obi_mem_responder #(.DEPTH_WORDS(1024), .RESP_LAT(2), .MAX_OUTSTANDING(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[1]), .gnt_o(gnt_v[1]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_v[1]), .rdata_o(rdata_v[1]),
        .err_o(err_v[1]), .stall_i(stall));

    cv32e40p_obi_mem_responder #(.DEPTH_WORDS(1024), .RESP_LAT(3), .MAX_OUTSTANDING(1)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[2]), .gnt_o(gnt_v[2]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_v[2]), .rdata_o(rdata_v[2]),
        .err_o(err_v[2]), .stall_i(stall));

    cv32e40p_obi_mem_responder #(.DEPTH_WORDS(1024), .RESP_LAT(4), .MAX_OUTSTANDING(2)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[3]), .gnt_o(gnt_v[3]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_v[3]), .rdata_o(rdata_v[3]),
        .err_o(err_v[3]), .stall_i(stall));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction on instance u; starts just after a rising edge and
    // returns just after a rising edge with the instance idle again.
    task automatic txn(input int u, input vec_t v, input string name);
        int waited;
        int first;
        int pulses;
        logic [31:0] got_rdata;
        logic        got_err;
        sel = 2'(u); we = v.we; addr = v.addr; be = v.be; wdata = v.wdata; req = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!gnt_v[u] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, " gnt_now"}, 32'(waited), 32'd0);
        if (!gnt_v[u]) begin
            req = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        req = 1'b0;
        first = 0; pulses = 0; got_rdata = 32'h0; got_err = 1'b0;
        for (int k = 1; k <= lats[u] + 2; k++) begin
            @(negedge clk);
            if (rvalid_v[u]) begin
                pulses++;
                if (first == 0) begin
                    first = k;
                    got_rdata = rdata_v[u];
                    got_err = err_v[u];
                end
            end
        end
        check({name, " latency"}, 32'(first), 32'(lats[u]));
        check({name, " pulses"}, 32'(pulses), 32'd1);
        check({name, " rdata"}, got_rdata, v.exp_rdata);
        check({name, " err"}, {31'h0, got_err}, {31'h0, v.exp_err});
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] seq_data [8];
        vec_t pre;
        int k;
        bit exp_rv;
        bit exp_g;

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hCAFE_BABE, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hCAFE_BABE, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h55AA_55AA, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h55AA_55AA, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h1234_5678, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_0FFF, 4'hF, 32'h0,         32'h1234_5678, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,         32'hCAFE_BABE, 1'b0};

        rst_n = 1'b0; req = 1'b0; sel = 2'd0; addr = 32'h0; we = 1'b0; be = 4'h0;
        wdata = 32'h0; stall = 1'b0;

        // Reset state of every instance.
        #3;
        for (int u = 0; u < 4; u++) begin
            check($sformatf("reset u%0d rvalid", u), {31'h0, rvalid_v[u]}, 32'h0);
            check($sformatf("reset u%0d rdata", u), rdata_v[u], 32'h0);
            check($sformatf("reset u%0d err", u), {31'h0, err_v[u]}, 32'h0);
            check($sformatf("reset u%0d gnt", u), {31'h0, gnt_v[u]}, 32'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of single transactions on the latency-1 instance.
        for (int i = 0; i < 12; i++) begin
            txn(0, vecs[i], $sformatf("vec%0d", i));
        end

        // Stall holds off grants; nothing is accepted.
        sel = 2'd0; we = 1'b0; addr = 32'h10; be = 4'hF; req = 1'b1; stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall gnt c%0d", c), {31'h0, gnt_v[0]}, 32'h0);
            check($sformatf("stall rvalid c%0d", c), {31'h0, rvalid_v[0]}, 32'h0);
            @(posedge clk); #1;
        end
        req = 1'b0; stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post-stall rvalid c%0d", c), {31'h0, rvalid_v[0]}, 32'h0);
            check($sformatf("post-stall rdata c%0d", c), rdata_v[0], 32'h0);
            @(posedge clk); #1;
        end

        // Latency 2 / two outstanding: eight back-to-back reads at full rate.
        for (int i = 0; i < 8; i++) begin
            seq_data[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
            pre = '{1'b1, 32'h100 + 32'(4 * i), 4'hF, seq_data[i], 32'h0, 1'b0};
            txn(1, pre, $sformatf("u1 prewrite%0d", i));
        end
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                sel = 2'd1; we = 1'b0; be = 4'hF; addr = 32'h100 + 32'(4 * c); req = 1'b1;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            if (c < 8) check($sformatf("b2b gnt c%0d", c), {31'h0, gnt_v[1]}, 32'h1);
            exp_rv = (c >= 2) && (c < 10);
            check($sformatf("b2b rvalid c%0d", c), {31'h0, rvalid_v[1]}, {31'h0, exp_rv});
            if (exp_rv) check($sformatf("b2b rdata c%0d", c), rdata_v[1], seq_data[c-2]);
            @(posedge clk); #1;
        end

        // Latency 3 / one outstanding: each grant waits for the predecessor's response.
        for (int i = 0; i < 3; i++) begin
            seq_data[i] = 32'h5000_0000 + 32'(i);
            pre = '{1'b1, 32'h200 + 32'(4 * i), 4'hF, seq_data[i], 32'h0, 1'b0};
            txn(2, pre, $sformatf("u2 prewrite%0d", i));
        end
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (k < 3) begin
                sel = 2'd2; we = 1'b0; be = 4'hF; addr = 32'h200 + 32'(4 * k); req = 1'b1;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            exp_g = (c == 0) || (c == 3) || (c == 6);
            exp_rv = (c == 3) || (c == 6) || (c == 9);
            check($sformatf("lat3 gnt c%0d", c), {31'h0, gnt_v[2]}, {31'h0, exp_g});
            check($sformatf("lat3 rvalid c%0d", c), {31'h0, rvalid_v[2]}, {31'h0, exp_rv});
            if (exp_rv) check($sformatf("lat3 rdata c%0d", c), rdata_v[2], seq_data[c/3 - 1]);
            if (req && gnt_v[2]) k++;
            @(posedge clk); #1;
        end

        // Latency 4: reset during the first response drops both in-flight responses.
        pre = '{1'b1, 32'h300, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0};
        txn(3, pre, "u3 prewrite");
        for (int c = 0; c < 2; c++) begin
            sel = 2'd3; we = 1'b0; be = 4'hF; addr = 32'h300; req = 1'b1;
            @(negedge clk);
            check($sformatf("rst pre gnt c%0d", c), {31'h0, gnt_v[3]}, 32'h1);
            @(posedge clk); #1;
        end
        req = 1'b0;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst pre rvalid c%0d", c), {31'h0, rvalid_v[3]}, 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst first rvalid", {31'h0, rvalid_v[3]}, 32'h1);
        check("rst first rdata", rdata_v[3], 32'h0BAD_F00D);
        #1 rst_n = 1'b0;
        #1;
        check("rst immediate rvalid", {31'h0, rvalid_v[3]}, 32'h0);
        check("rst immediate rdata", rdata_v[3], 32'h0);
        check("rst immediate err", {31'h0, err_v[3]}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst held rvalid", {31'h0, rvalid_v[3]}, 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            if (c < 2) begin
                sel = 2'd3; we = 1'b0; be = 4'hF; addr = 32'h300; req = 1'b1;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            if (c < 2) check($sformatf("post-rst gnt c%0d", c), {31'h0, gnt_v[3]}, 32'h1);
            exp_rv = (c == 4) || (c == 5);
            check($sformatf("post-rst rvalid c%0d", c), {31'h0, rvalid_v[3]}, {31'h0, exp_rv});
            check($sformatf("post-rst rdata c%0d", c), rdata_v[3],
                  exp_rv ? 32'h0BAD_F00D : 32'h0);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
